// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants and types for the 3x3 systolic matrix
// multiplier behind an AXI-stream style wrapper.
//   N         matrix dimension (3)
//   DATA_W    operand width (8, unsigned)
//   ACC_W     accumulator / result element width (16)
//   BEAT_W    input beat width: N A-column bytes then N B-row bytes
//   RES_W     flattened result width, C[i][j] at [(N*i+j)*ACC_W +: ACC_W]
//   sa_state_t  wrapper FSM state encoding
package systolic_pkg;

  localparam int N      = 3;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int BEAT_W = 2 * N * DATA_W;
  localparam int RES_W  = N * N * ACC_W;

  // Skewed wavefront needs 3N-2 cycles to reach the far corner PE.
  // The compute timer counts down from COMPUTE_LAST to 0.
  localparam int COMPUTE_LAST = 3 * N - 3;
  localparam int CNT_W        = 3;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } sa_state_t;

endpackage

// File: rtl/systolic_array_axi_wrapper_pe.sv
// sa_pe: one multiply-accumulate cell of the systolic grid.
//   axi_clk    clock
//   axi_rst_n  synchronous active-low reset
//   clear      synchronous clear of accumulator and forwarding registers
//   a_in/a_out A operand, forwarded rightward through a register
//   b_in/b_out B operand, forwarded downward through a register
//   acc        accumulated dot product
// Build option: SA_SATURATE_EN makes the accumulator clamp at all-ones
// instead of wrapping.
module sa_pe
  import systolic_pkg::*;
(
  input  logic              axi_clk,
  input  logic              axi_rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] prod;

  assign prod = ACC_W'(a_in) * ACC_W'(b_in);

`ifdef SA_SATURATE_EN
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, prod};
`endif

  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n || clear) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
`ifdef SA_SATURATE_EN
      acc   <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc   <= acc + prod;
`endif
    end
  end

endmodule

// File: rtl/systolic_array_axi_wrapper.sv
// systolic_array_axi_wrapper: 3x3 unsigned matrix multiplier C = A x B.
// A and B arrive as three input beats (k = 0..2), each carrying column k
// of A and row k of B; the result matrix is presented as one output beat.
//   axi_clk       clock
//   axi_rst_n     synchronous active-low reset
//   s_axis_valid  input beat valid
//   s_axis_data   [7:0],[15:8],[23:16] = A[0..2][k]; [31:24],[39:32],[47:40] = B[k][0..2]
//   s_axis_ready  high while loading beats
//   m_axis_valid  result valid, held until m_axis_ready
//   m_axis_data   C[i][j] at [(3*i+j)*16 +: 16], zero while m_axis_valid is low
//   m_axis_ready  downstream accepts the result
// Build option: SA_SATURATE_EN (see sa_pe) clamps accumulators at 16'hFFFF.
//
// FSM states:
//   state   | meaning
//   LOAD    | accepting beats, beat_cnt counts 0..2
//   COMPUTE | skewed operands flow through the grid, compute_cnt counts down
//   OUTPUT  | result held on m_axis_*, waiting for m_axis_ready
module systolic_array_axi_wrapper
  import systolic_pkg::*;
(
  input  logic              axi_clk,
  input  logic              axi_rst_n,
  input  logic              s_axis_valid,
  input  logic [BEAT_W-1:0] s_axis_data,
  output logic              s_axis_ready,
  output logic              m_axis_valid,
  output logic [RES_W-1:0]  m_axis_data,
  input  logic              m_axis_ready
);

  sa_state_t          state;
  logic [1:0]         beat_cnt;
  logic [CNT_W-1:0]   compute_cnt;
  logic [CNT_W-1:0]   t_idx;
  logic               accept;
  logic               clear_grid;

  logic [DATA_W-1:0]  a_buf [N][N];  // a_buf[i][k] = A[i][k]
  logic [DATA_W-1:0]  b_buf [N][N];  // b_buf[k][j] = B[k][j]
  logic [DATA_W-1:0]  a_inj [N];
  logic [DATA_W-1:0]  b_inj [N];

  logic [DATA_W-1:0]  a_h [N][N+1];
  logic [DATA_W-1:0]  b_v [N+1][N];
  logic [RES_W-1:0]   acc_flat;
  logic               unused_edge;

  assign accept     = (state == LOAD) && s_axis_valid && s_axis_ready;
  assign clear_grid = (state == OUTPUT) && m_axis_ready;

  // Wavefront time: 0 on the first compute cycle, COMPUTE_LAST on the last.
  assign t_idx = CNT_W'(COMPUTE_LAST) - compute_cnt;

  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) begin
      state        <= LOAD;
      beat_cnt     <= '0;
      compute_cnt  <= '0;
      s_axis_ready <= 1'b1;
      m_axis_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (beat_cnt == 2'(N - 1)) begin
              beat_cnt     <= '0;
              compute_cnt  <= CNT_W'(COMPUTE_LAST);
              s_axis_ready <= 1'b0;
              state        <= COMPUTE;
            end else begin
              beat_cnt <= beat_cnt + 2'd1;
            end
          end
        end
        COMPUTE: begin
          // The last accumulate lands on the same edge that raises valid.
          if (compute_cnt == '0) begin
            m_axis_valid <= 1'b1;
            state        <= OUTPUT;
          end else begin
            compute_cnt <= compute_cnt - 1'b1;
          end
        end
        OUTPUT: begin
          if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
            s_axis_ready <= 1'b1;
            state        <= LOAD;
          end
        end
        default: begin
          state        <= LOAD;
          beat_cnt     <= '0;
          s_axis_ready <= 1'b1;
          m_axis_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          a_buf[i][k] <= '0;
          b_buf[i][k] <= '0;
        end
      end
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        if (beat_cnt == 2'(k)) begin
          for (int i = 0; i < N; i++) begin
            a_buf[i][k] <= s_axis_data[i*DATA_W +: DATA_W];
            b_buf[k][i] <= s_axis_data[(N+i)*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Row i is delayed by i cycles and column j by j cycles, so PE(i,j)
  // sees A[i][k] and B[k][j] together at t = i + j + k. Outside that
  // window the edges inject zero, which keeps the accumulators frozen.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_inj[i] = '0;
      b_inj[i] = '0;
    end
    if (state == COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_idx) == i + k) begin
            a_inj[i] = a_buf[i][k];
            b_inj[i] = b_buf[k][i];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign a_h[gi][0] = a_inj[gi];
    assign b_v[0][gi] = b_inj[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      sa_pe u_pe (
        .axi_clk   (axi_clk),
        .axi_rst_n (axi_rst_n),
        .clear     (clear_grid),
        .a_in      (a_h[gi][gj]),
        .b_in      (b_v[gi][gj]),
        .a_out     (a_h[gi][gj+1]),
        .b_out     (b_v[gi+1][gj]),
        .acc       (acc_flat[(N*gi+gj)*ACC_W +: ACC_W])
      );
    end
  end

  // Operands leaving the far edges of the grid are not needed.
  assign unused_edge = ^{a_h[0][N], a_h[1][N], a_h[2][N],
                         b_v[N][0], b_v[N][1], b_v[N][2]};

  assign m_axis_data = m_axis_valid ? acc_flat : '0;

endmodule

// File: tb/tb_systolic_array_axi_wrapper.sv
module tb_systolic_array_axi_wrapper;

  logic         axi_clk;
  logic         axi_rst_n;
  logic         s_axis_valid;
  logic [47:0]  s_axis_data;
  logic         s_axis_ready;
  logic         m_axis_valid;
  logic [143:0] m_axis_data;
  logic         m_axis_ready;

  int n_cmp;
  int n_bad;

  systolic_array_axi_wrapper dut (
    .axi_clk      (axi_clk),
    .axi_rst_n    (axi_rst_n),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_ready (s_axis_ready),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_ready (m_axis_ready)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [47:0] beat [3];
    int          c [9];
    int          idle;
    int          hold;
    bit          poke;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [143:0] got, input logic [143:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain matrix product from the beat layout, then wrap or clamp.
  function automatic logic [143:0] model(input logic [47:0] b0, input logic [47:0] b1,
                                         input logic [47:0] b2);
    logic [47:0]  bt [3];
    int           a [3][3];
    int           b [3][3];
    int           s;
    logic [143:0] r;
    bt[0] = b0; bt[1] = b1; bt[2] = b2;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        a[i][k] = int'(bt[k][8*i +: 8]);
        b[k][i] = int'(bt[k][8*(3+i) +: 8]);
      end
    end
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += a[i][k] * b[k][j];
`ifdef SA_SATURATE_EN
        if (s > 65535) s = 65535;
`else
        s = s % 65536;
`endif
        r[(3*i+j)*16 +: 16] = 16'(s);
      end
    end
    return r;
  endfunction

  task automatic send_beat(input logic [47:0] d);
    @(negedge axi_clk);
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    @(posedge axi_clk);
    #1;
    s_axis_valid = 1'b0;
    s_axis_data  = 48'($urandom) ^ {$urandom, 16'h0};
  endtask

  // Loads one matrix, measures latency from the 3rd accept, optionally
  // holds m_axis_ready low, then completes the handshake.
  task automatic run_matrix(input logic [47:0] b0, input logic [47:0] b1, input logic [47:0] b2,
                            input int idle, input int hold, input bit poke,
                            output logic [143:0] res, output int lat,
                            output int ready_leak, output int hold_bad, output int post_bad);
    ready_leak = 0;
    hold_bad   = 0;
    post_bad   = 0;
    lat        = -1;
    m_axis_ready = (hold == 0);
    send_beat(b0);
    repeat (idle) @(posedge axi_clk);
    send_beat(b1);
    repeat (idle) @(posedge axi_clk);
    send_beat(b2);
    if (poke) begin
      s_axis_valid = 1'b1;
      s_axis_data  = 48'hFFFF_FFFF_FFFF;
    end
    for (int e = 1; e <= 20; e++) begin
      @(posedge axi_clk);
      #1;
      if (s_axis_ready !== 1'b0) ready_leak++;
      if (m_axis_valid === 1'b1) begin
        lat = e;
        break;
      end
    end
    res = m_axis_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge axi_clk);
      #1;
      if (m_axis_valid !== 1'b1 || m_axis_data !== res) hold_bad++;
      if (s_axis_ready !== 1'b0) ready_leak++;
    end
    s_axis_valid = 1'b0;
    m_axis_ready = 1'b1;
    @(posedge axi_clk);
    #1;
    m_axis_ready = 1'b0;
    if (m_axis_valid !== 1'b0 || m_axis_data !== '0 || s_axis_ready !== 1'b1) post_bad++;
  endtask

  task automatic run_and_check(input string tag, input logic [47:0] b0, input logic [47:0] b1,
                               input logic [47:0] b2, input int idle, input int hold,
                               input bit poke, input logic [143:0] exp);
    logic [143:0] res;
    int lat, leak, hbad, pbad;
    run_matrix(b0, b1, b2, idle, hold, poke, res, lat, leak, hbad, pbad);
    check($sformatf("%s result", tag), res, exp);
    check($sformatf("%s latency", tag), 144'(lat), 144'(7));
    check($sformatf("%s ready_low", tag), 144'(leak), 144'(0));
    check($sformatf("%s hold", tag), 144'(hbad), 144'(0));
    check($sformatf("%s post_handshake", tag), 144'(pbad), 144'(0));
  endtask

  logic [143:0] exp_c;
  logic [47:0]  rb [3];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    axi_rst_n    = 1'b0;
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
    m_axis_ready = 1'b0;

    // Worked examples.
    tbl[0].beat[0] = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    tbl[0].beat[1] = {8'd12, 8'd11, 8'd10, 8'd8, 8'd5, 8'd2};
    tbl[0].beat[2] = {8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
    tbl[0].c = '{132, 123, 114, 157, 153, 149, 182, 183, 184};
    tbl[0].idle = 3; tbl[0].hold = 0; tbl[0].poke = 1'b0;

    tbl[1].beat[0] = {8'd3, 8'd2, 8'd1, 8'd16, 8'd13, 8'd10};
    tbl[1].beat[1] = {8'd6, 8'd5, 8'd4, 8'd17, 8'd14, 8'd11};
    tbl[1].beat[2] = {8'd9, 8'd8, 8'd7, 8'd18, 8'd15, 8'd12};
    tbl[1].c = '{138, 171, 204, 174, 216, 258, 210, 261, 312};
    tbl[1].idle = 0; tbl[1].hold = 4; tbl[1].poke = 1'b0;

    tbl[2].beat[0] = 48'hFFFF_FFFF_FFFF;
    tbl[2].beat[1] = 48'hFFFF_FFFF_FFFF;
    tbl[2].beat[2] = 48'hFFFF_FFFF_FFFF;
`ifdef SA_SATURATE_EN
    tbl[2].c = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
`else
    tbl[2].c = '{64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003};
`endif
    tbl[2].idle = 0; tbl[2].hold = 1; tbl[2].poke = 1'b1;

    // Identity A: C equals B; also checks the 4th beat offered above was dropped.
    tbl[3].beat[0] = {8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd1};
    tbl[3].beat[1] = {8'd6, 8'd5, 8'd4, 8'd0, 8'd1, 8'd0};
    tbl[3].beat[2] = {8'd9, 8'd8, 8'd7, 8'd1, 8'd0, 8'd0};
    tbl[3].c = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    tbl[3].idle = 1; tbl[3].hold = 2; tbl[3].poke = 1'b0;

    repeat (3) @(posedge axi_clk);
    #1;
    axi_rst_n = 1'b1;
    check("reset s_axis_ready", 144'(s_axis_ready), 144'(1));
    check("reset m_axis_valid", 144'(m_axis_valid), 144'(0));
    check("reset m_axis_data", m_axis_data, '0);

    for (int v = 0; v < 4; v++) begin
      exp_c = '0;
      for (int k = 0; k < 9; k++) exp_c[k*16 +: 16] = 16'(tbl[v].c[k]);
      check($sformatf("vec%0d model", v),
            model(tbl[v].beat[0], tbl[v].beat[1], tbl[v].beat[2]), exp_c);
      run_and_check($sformatf("vec%0d", v), tbl[v].beat[0], tbl[v].beat[1], tbl[v].beat[2],
                    tbl[v].idle, tbl[v].hold, tbl[v].poke, exp_c);
    end

    // Reset after two beats: partial data must be discarded.
    send_beat(48'h0102_0304_0506);
    send_beat(48'h0708_090A_0B0C);
    @(negedge axi_clk);
    axi_rst_n = 1'b0;
    repeat (2) @(posedge axi_clk);
    #1;
    axi_rst_n = 1'b1;
    check("midload reset ready", 144'(s_axis_ready), 144'(1));
    run_and_check("after_midload_reset", tbl[1].beat[0], tbl[1].beat[1], tbl[1].beat[2],
                  0, 0, 1'b0, model(tbl[1].beat[0], tbl[1].beat[1], tbl[1].beat[2]));

    // Reset in the middle of COMPUTE.
    send_beat(48'h1111_1111_1111);
    send_beat(48'h2222_2222_2222);
    send_beat(48'h3333_3333_3333);
    repeat (3) @(posedge axi_clk);
    #1;
    axi_rst_n = 1'b0;
    @(posedge axi_clk);
    #1;
    check("midcompute reset valid", 144'(m_axis_valid), 144'(0));
    check("midcompute reset data", m_axis_data, '0);
    check("midcompute reset ready", 144'(s_axis_ready), 144'(1));
    axi_rst_n = 1'b1;
    run_and_check("after_midcompute_reset", tbl[0].beat[0], tbl[0].beat[1], tbl[0].beat[2],
                  1, 1, 1'b0, model(tbl[0].beat[0], tbl[0].beat[1], tbl[0].beat[2]));

    // Randomized matrices against the reference model.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 3; k++) rb[k] = {16'($urandom), 32'($urandom)};
      if (r == 0) for (int k = 0; k < 3; k++) rb[k] = {24'hFFFFFF, 24'($urandom) | 24'hF0F0F0};
      run_and_check($sformatf("rand%0d", r), rb[0], rb[1], rb[2],
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), model(rb[0], rb[1], rb[2]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_array_axi_wrapper.md
SYSTOLIC_ARRAY_AXI_WRAPPER -- requirements
Module: systolic_array_axi_wrapper

Interface
REQ-001 Parameters SHALL be none; dimensions N=3, DATA_W=8 and ACC_W=16 SHALL be fixed by package constants.
REQ-002 axi_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 axi_rst_n  input  1  reset; synchronous, active-low.
REQ-004 s_axis_valid  input  1  input beat valid.
REQ-005 s_axis_data  input  48  input beat: bytes [7:0],[15:8],[23:16] = A[0][k],A[1][k],A[2][k]; bytes [31:24],[39:32],[47:40] = B[k][0],B[k][1],B[k][2].
REQ-006 s_axis_ready  output  1  block can accept an input beat.
REQ-007 m_axis_valid  output  1  result matrix valid.
REQ-008 m_axis_data  output  144  C[i][j] at bits [(3*i+j)*16 +: 16].
REQ-009 m_axis_ready  input  1  downstream accepts the result.

Function
REQ-010 The block SHALL compute C = A x B for 3x3 unsigned 8-bit matrices, sent as 3 beats, k = 0,1,2.
REQ-011 FSM states SHALL be LOAD, COMPUTE and OUTPUT.
REQ-012 LOAD: s_axis_ready=1; a beat SHALL be accepted only on a rising edge with s_axis_valid & s_axis_ready; idle cycles between beats SHALL be allowed.
REQ-013 Accepting the 3rd beat SHALL move the FSM to COMPUTE; s_axis_ready SHALL be 0 in COMPUTE and OUTPUT, and s_axis_valid SHALL be ignored there.
REQ-014 COMPUTE SHALL feed a 3x3 PE grid with skewed A and B operands; each PE SHALL perform acc += a*b.
REQ-015 The product SHALL be 16 bits; accumulation SHALL be modulo 2^16 (see REQ-024).
REQ-016 m_axis_valid SHALL rise exactly 7 rising edges after the edge that accepted the 3rd beat; on that edge the FSM SHALL enter OUTPUT.
REQ-017 OUTPUT: m_axis_valid=1 and m_axis_data SHALL hold stable until a rising edge with m_axis_ready=1.
REQ-018 On that edge the FSM SHALL return to LOAD, m_axis_valid SHALL drop to 0, and all accumulators SHALL clear.
REQ-019 m_axis_ready SHALL have no effect outside OUTPUT.
REQ-020 m_axis_data SHALL be 0 whenever m_axis_valid=0.
REQ-021 Back-to-back matrices SHALL be supported; the first beat of the next matrix SHALL be acceptable on the cycle after the output handshake.

Reset
REQ-022 While axi_rst_n=0 at a rising edge, the block SHALL set FSM=LOAD, beat count=0, accumulators=0, skew pipelines=0, m_axis_valid=0 and m_axis_data=0; s_axis_ready SHALL read 1 once reset releases.
REQ-023 Reset in any state, including mid-load and mid-compute, SHALL abort the operation and discard partial data.

Configuration
REQ-024 With SA_SATURATE_EN defined, each accumulator SHALL clamp at 16'hFFFF and not wrap; without it, accumulation SHALL wrap modulo 2^16.

Structure
REQ-025 Package systolic_pkg SHALL hold N, DATA_W, ACC_W and the FSM state enum typedef.
REQ-026 Sub-module sa_pe SHALL hold the single multiply-accumulate cell: it SHALL forward a rightward and b downward, each registered, and keep a clear input; the wrapper SHALL instantiate 9 copies.

Verification
REQ-027 Beats {6,5,4,3,2,1}, {12,11,10,8,5,2}, {7,8,9,10,11,12}, with 3 idle cycles between beats and m_axis_ready=1 -> C[0..8] = 132,123,114,157,153,149,182,183,184; m_axis_valid high for 1 cycle.
REQ-028 Next, back-to-back beats {3,2,1,16,13,10}, {6,5,4,17,14,11}, {9,8,7,18,15,12} with m_axis_ready=0 -> C = 138,171,204,174,216,258,210,261,312; valid and data held until m_axis_ready=1.
REQ-029 Latency check: m_axis_valid SHALL rise 7 edges after the 3rd accept; s_axis_ready SHALL be 0 from the 3rd accept until the output handshake, and a 4th beat offered then SHALL be ignored.
REQ-030 All bytes 255 -> every C = 64003 without SA_SATURATE_EN, 65535 with it.
REQ-031 Reset asserted after 2 beats, then a full valid matrix -> result SHALL equal a fresh computation of that matrix alone.
